// File: rtl/alu_mc_ysyx_if.sv
// Handshake and operand/result bundle for alu_mc_ysyx.
interface alu_mc_ysyx_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            less;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, op, src_a, src_b, flush, out_ready,
    input  in_ready, out_valid, result, less, zero, illegal
  );

  modport slave (
    input  in_valid, op, src_a, src_b, flush, out_ready,
    output in_ready, out_valid, result, less, zero, illegal
  );
endinterface

// File: rtl/alu_mc_ysyx.sv
// Multi-cycle RV ALU; the M-group multiply/divide datapath is built only when
// ALU_MULDIV_EN is defined, otherwise every op[4]=1 bundle is reported illegal.
module alu_mc_ysyx #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input logic          clk,
  input logic          rst,
  alu_mc_ysyx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state_q, state_d;

  logic [XLEN-1:0] a, b;
  logic            accept, iter_op, last_iter;
  logic [XLEN-1:0] result_q;
  logic            less_q, zero_q, illegal_q;

  assign a      = bus.src_a;
  assign b      = bus.src_b;
  assign accept = bus.in_valid && bus.in_ready && !bus.flush;

  logic [XLEN:0]   sub_w;
  logic            slt_w, sltu_w;
  logic [XLEN-1:0] base_res;
  logic            base_less, base_ill;

  assign sub_w  = {1'b0, a} - {1'b0, b};
  assign sltu_w = sub_w[XLEN];
  assign slt_w  = sub_w[XLEN-1] ^ ((a[XLEN-1] ^ b[XLEN-1]) & (sub_w[XLEN-1] ^ a[XLEN-1]));

  always_comb begin
    base_res  = '0;
    base_less = 1'b0;
    base_ill  = 1'b0;
    case (bus.op[3:0])
      4'b0000: base_res = a + b;
      4'b1000: base_res = sub_w[XLEN-1:0];
      4'b0011: base_res = b;
      4'b1010: begin base_less = sltu_w; base_res = {{(XLEN-1){1'b0}}, sltu_w}; end
      4'b0010: begin base_less = slt_w;  base_res = {{(XLEN-1){1'b0}}, slt_w};  end
      4'b0100: base_res = a ^ b;
      4'b0110: base_res = a | b;
      4'b0111: base_res = a & b;
      4'b0001: base_res = a << b[SHW-1:0];
      4'b0101: base_res = a >> b[SHW-1:0];
      4'b1101: base_res = $signed(a) >>> b[SHW-1:0];
      default: base_ill = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic              m_ill, a_sgn, b_sgn, sa, sb, div_spec, div_ge;
  logic [XLEN-1:0]   amag, bmag, spec_res, mul_res, div_res, quot, rem;
  logic [XLEN-1:0]   dvs_q;
  logic [2*XLEN-1:0] acc_q, mul_next, div_next, prod_s;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [1:0]        mop_q;
  logic              negq_q, negr_q;
  logic [SHW-1:0]    cnt_q;

  assign m_ill    = bus.op[3];
  assign a_sgn    = bus.op[2] ? !bus.op[0] : (bus.op[1:0] != 2'b11);
  assign b_sgn    = bus.op[2] ? !bus.op[0] : !bus.op[1];
  assign sa       = a_sgn & a[XLEN-1];
  assign sb       = b_sgn & b[XLEN-1];
  assign amag     = sa ? -a : a;
  assign bmag     = sb ? -b : b;
  assign div_spec = bus.op[2] && ((b == '0) ||
                    (!bus.op[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1));
  assign spec_res = bus.op[1] ? ((b == '0) ? a : '0)
                              : ((b == '0) ? '1 : {1'b1, {(XLEN-1){1'b0}}});
  assign iter_op   = bus.op[4] && !m_ill && !div_spec;
  assign last_iter = (state_q == MUL || state_q == DIV) && cnt_q == SHW'(XLEN-1);

  // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
  assign div_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff = div_sh - {1'b0, dvs_q};
  assign div_ge   = !div_diff[XLEN];
  assign div_next = {div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0], acc_q[XLEN-2:0], div_ge};

  assign prod_s  = negq_q ? -mul_next : mul_next;
  assign mul_res = (mop_q == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  assign quot    = div_next[XLEN-1:0];
  assign rem     = div_next[2*XLEN-1:XLEN];
  assign div_res = mop_q[1] ? (negr_q ? -rem : rem) : (negq_q ? -quot : quot);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      dvs_q  <= '0;
      mop_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      cnt_q  <= '0;
    end else if (bus.flush) begin
      cnt_q <= '0;
    end else if (accept && iter_op) begin
      acc_q  <= {{XLEN{1'b0}}, bus.op[2] ? amag : bmag};
      dvs_q  <= bus.op[2] ? bmag : amag;
      mop_q  <= bus.op[1:0];
      negq_q <= sa ^ sb;
      negr_q <= sa;
      cnt_q  <= '0;
    end else if (state_q == MUL || state_q == DIV) begin
      acc_q <= (state_q == MUL) ? mul_next : div_next;
      cnt_q <= last_iter ? '0 : cnt_q + 1'b1;
    end
  end
`else
  assign iter_op   = 1'b0;
  assign last_iter = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (accept) state_d = iter_op ? (bus.op[2] ? DIV : MUL) : DONE;
        MUL, DIV: if (last_iter) state_d = DONE;
        DONE:     if (bus.out_ready) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  logic            load_en, load_less, load_ill;
  logic [XLEN-1:0] load_res;

  always_comb begin
    load_en   = 1'b0;
    load_res  = '0;
    load_less = 1'b0;
    load_ill  = 1'b0;
    if (accept && !iter_op) begin
      load_en = 1'b1;
      if (!bus.op[4]) begin
        load_res  = base_res;
        load_less = base_less;
        load_ill  = base_ill;
      end else begin
`ifdef ALU_MULDIV_EN
        load_ill = m_ill;
        load_res = m_ill ? '0 : spec_res;
`else
        load_ill = 1'b1;
`endif
      end
    end
`ifdef ALU_MULDIV_EN
    else if (last_iter) begin
      load_en  = 1'b1;
      load_res = (state_q == MUL) ? mul_res : div_res;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || bus.flush) begin
      result_q  <= '0;
      less_q    <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (load_en) begin
      result_q  <= load_res;
      less_q    <= load_less;
      zero_q    <= (load_res == '0);
      illegal_q <= load_ill;
    end
  end

  assign bus.result  = result_q;
  assign bus.less    = less_q;
  assign bus.zero    = zero_q;
  assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_alu_mc_ysyx.sv
// Self-checking bench for alu_mc_ysyx (XLEN=32); expectations follow ALU_MULDIV_EN.
module tb_alu_mc_ysyx;
  localparam int unsigned XLEN = 32;
`ifdef ALU_MULDIV_EN
  localparam int MLAT = XLEN + 1;
`else
  localparam int MLAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mc_ysyx_if #(.XLEN(XLEN)) bus();
  alu_mc_ysyx #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    bit          l;
    bit          ill;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output bit l, output bit ill, output int lat);
    longint          p;
    longint unsigned pu;
    int              sa, sb;
    r = 32'h0; l = 1'b0; ill = 1'b0; lat = 1;
    sa = int'(a); sb = int'(b);
    if (!op[4]) begin
      case (op[3:0])
        4'b0000: r = a + b;
        4'b1000: r = a - b;
        4'b0011: r = b;
        4'b1010: begin l = (a < b); r = {31'b0, l}; end
        4'b0010: begin l = (sa < sb); r = {31'b0, l}; end
        4'b0100: r = a ^ b;
        4'b0110: r = a | b;
        4'b0111: r = a & b;
        4'b0001: r = a << b[4:0];
        4'b0101: r = a >> b[4:0];
        4'b1101: r = 32'(sa >>> b[4:0]);
        default: ill = 1'b1;
      endcase
    end else begin
`ifdef ALU_MULDIV_EN
      lat = XLEN + 1;
      case (op[3:0])
        4'b0000: r = a * b;
        4'b0001: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
        4'b0010: begin p = longint'(sa) * longint'({32'b0, b}); r = p[63:32]; end
        4'b0011: begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
        4'b0100, 4'b0110: begin
          if (b == 0) begin r = op[1] ? a : 32'hFFFFFFFF; lat = 1; end
          else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            r = op[1] ? 32'h0 : 32'h80000000; lat = 1;
          end else r = op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        4'b0101, 4'b0111: begin
          if (b == 0) begin r = op[1] ? a : 32'hFFFFFFFF; lat = 1; end
          else r = op[1] ? a % b : a / b;
        end
        default: begin ill = 1'b1; lat = 1; end
      endcase
`else
      ill = 1'b1;
`endif
    end
  endfunction

  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input bit el, input bit eill, input int elat, input int hold);
    int lat;
    bus.op = op; bus.src_a = a; bus.src_b = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "/out_valid"}, 64'(bus.out_valid), 64'd1);
    chk({name, "/latency"}, 64'(lat), 64'(elat));
    chk({name, "/result"}, 64'(bus.result), 64'(er));
    chk({name, "/less"}, 64'(bus.less), 64'(el));
    chk({name, "/zero"}, 64'(bus.zero), 64'(er == 32'h0));
    chk({name, "/illegal"}, 64'(bus.illegal), 64'(eill));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, "/held_result"}, 64'(bus.result), 64'(er));
      chk({name, "/held_valid"}, 64'(bus.out_valid), 64'd1);
      chk({name, "/held_in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({name, "/in_ready_after"}, 64'(bus.in_ready), 64'd1);
    chk({name, "/valid_after"}, 64'(bus.out_valid), 64'd0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[$];
    logic [4:0]  legal_ops [19];
    logic [4:0]  op;
    logic [31:0] a, b, er;
    bit          el, eill;
    int          elat, seen;

    legal_ops = '{5'b00000, 5'b01000, 5'b00011, 5'b01010, 5'b00010, 5'b00100, 5'b00110,
                  5'b00111, 5'b00001, 5'b00101, 5'b01101, 5'b10000, 5'b10001, 5'b10010,
                  5'b10011, 5'b10100, 5'b10101, 5'b10110, 5'b10111};

    bus.in_valid = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    #12;
    chk("reset/in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset/out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset/result", 64'(bus.result), 64'd0);
    chk("reset/less", 64'(bus.less), 64'd0);
    chk("reset/zero", 64'(bus.zero), 64'd0);
    chk("reset/illegal", 64'(bus.illegal), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    tbl.push_back('{"add_wrap", 5'b00000, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1});
    tbl.push_back('{"slt_min", 5'b00010, 32'h80000000, 32'h1, 32'h1, 1'b1, 1'b0, 1});
    tbl.push_back('{"sltu_min", 5'b01010, 32'h80000000, 32'h1, 32'h0, 1'b0, 1'b0, 1});
    tbl.push_back('{"sub_neg", 5'b01000, 32'h5, 32'h7, 32'hFFFFFFFE, 1'b0, 1'b0, 1});
    tbl.push_back('{"lui", 5'b00011, 32'h123, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1});
    tbl.push_back('{"xor", 5'b00100, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0, 1'b0, 1});
    tbl.push_back('{"or", 5'b00110, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0, 1'b0, 1});
    tbl.push_back('{"and", 5'b00111, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0, 1});
    tbl.push_back('{"sll_mask", 5'b00001, 32'h1, 32'h23, 32'h8, 1'b0, 1'b0, 1});
    tbl.push_back('{"srl", 5'b00101, 32'h80000000, 32'h1F, 32'h1, 1'b0, 1'b0, 1});
    tbl.push_back('{"sra", 5'b01101, 32'h80000000, 32'h4, 32'hF8000000, 1'b0, 1'b0, 1});
    tbl.push_back('{"base_illegal", 5'b01111, 32'h3, 32'h4, 32'h0, 1'b0, 1'b1, 1});
`ifdef ALU_MULDIV_EN
    tbl.push_back('{"mulh", 5'b10001, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 1'b0, 1'b0, MLAT});
    tbl.push_back('{"mul", 5'b10000, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFEB, 1'b0, 1'b0, MLAT});
    tbl.push_back('{"div_by0", 5'b10100, 32'h7, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1});
    tbl.push_back('{"rem_by0", 5'b10110, 32'h7, 32'h0, 32'h7, 1'b0, 1'b0, 1});
    tbl.push_back('{"div_ovf", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b0, 1});
    tbl.push_back('{"m_illegal", 5'b11000, 32'h7, 32'h3, 32'h0, 1'b0, 1'b1, 1});
`else
    tbl.push_back('{"mulh", 5'b10001, 32'hFFFFFFFD, 32'h7, 32'h0, 1'b0, 1'b1, 1});
    tbl.push_back('{"mul", 5'b10000, 32'hFFFFFFFD, 32'h7, 32'h0, 1'b0, 1'b1, 1});
    tbl.push_back('{"div_by0", 5'b10100, 32'h7, 32'h0, 32'h0, 1'b0, 1'b1, 1});
    tbl.push_back('{"div_ovf", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1, 1});
`endif
    foreach (tbl[i])
      run_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].l, tbl[i].ill, tbl[i].lat, 0);

`ifdef ALU_MULDIV_EN
    run_op("divu_hold", 5'b10101, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, MLAT, 5);
    run_op("remu", 5'b10111, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, MLAT, 0);
`else
    run_op("divu_hold", 5'b10101, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1, MLAT, 5);
    run_op("remu", 5'b10111, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1, MLAT, 0);
`endif

    // flush ten cycles into a divide
    bus.op = 5'b10100; bus.src_a = 32'd1000; bus.src_b = 32'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush/out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush/in_ready", 64'(bus.in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("flush/no_late_valid", 64'(seen), 64'd0);
    run_op("add_after_flush", 5'b00000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, 0);

    // flush wins over a simultaneous accept
    bus.op = 5'b00000; bus.src_a = 32'd9; bus.src_b = 32'd9; bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    chk("flush_accept/out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_accept/in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    chk("flush_accept/out_valid2", 64'(bus.out_valid), 64'd0);

    run_op("add_before_rst", 5'b00000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, 0);
    bus.op = 5'b10000; bus.src_a = 32'h12345; bus.src_b = 32'h777; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_mid/in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_mid/out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid/result", 64'(bus.result), 64'd0);
    chk("rst_mid/less", 64'(bus.less), 64'd0);
    chk("rst_mid/zero", 64'(bus.zero), 64'd0);
    chk("rst_mid/illegal", 64'(bus.illegal), 64'd0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid/valid_after", 64'(bus.out_valid), 64'd0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) op = ($urandom_range(0, 1) == 0) ? 5'b01111 : 5'b11010;
      else op = legal_ops[$urandom_range(0, 18)];
      a = rnd_val();
      b = rnd_val();
      ref_model(op, a, b, er, el, eill, elat);
      run_op($sformatf("rand%0d_op%05b", n, op), op, a, b, er, el, eill, elat, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_mc_ysyx.md
# alu_mc_ysyx

Multi-cycle, parametrised successor to the NPC single-cycle ALU. It runs the RV base integer ALU operations plus, when compiled in, the RV M-extension multiply/divide group. Operands enter through a valid/ready handshake and results leave through one; base ops take one cycle, multiply/divide iterate one bit per cycle. It sits in EXU after the operand muxes (pc/rs1, rs2/imm/4 selection stays outside) and feeds the LSU/WBU stage.

## Interface
- XLEN, 32: datapath width; legal values 32 and 64.
- SHW, $clog2(XLEN): shift-amount width, derived; not overridden.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand/op bundle valid.
- in_ready  out  1  block can accept a bundle.
- op  in  5  {op[4]=M-group, op[3:0]=ctr}.
- src_a  in  XLEN  operand A (already muxed).
- src_b  in  XLEN  operand B (already muxed).
- flush  in  1  abort any in-flight operation.
- out_valid  out  1  result bundle valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  result (compare ops give zero-extended less).
- less  out  1  compare outcome; 0 for non-compare ops.
- zero  out  1  result == 0.
- illegal  out  1  op not supported in this build.

## Operation
- Base encodings (op[4]=0): 0000 add, 1000 sub, 0011 pass-B (lui), 1010 sltu, 0010 slt, 0100 xor, 0110 or, 0111 and, 0001 sll, 0101 srl, 1101 sra; other codes → result 0, illegal=1.
- Shifts use src_b[SHW-1:0] only. slt less = signed A<B, with overflow-corrected sign of A−B. sltu less = borrow of A−B. Wrap-around is modulo 2^XLEN.
- M encodings (op[4]=1): 0000 mul, 0001 mulh, 0010 mulhsu, 0011 mulhu, 0100 div, 0101 divu, 0110 rem, 0111 remu; 1xxx → illegal=1.
- Multiply: radix-2 shift-add on magnitudes into a 2·XLEN accumulator. The sign is fixed up on completion. mul returns the low half; mulh* return the high half.
- Divide: restoring, one quotient bit per cycle on magnitudes. Quotient takes sign A^B and remainder takes sign A.
- Divide special cases short-circuit and do not iterate:
  - b==0: quotient all-ones, remainder = A.
  - signed MIN/−1: quotient = MIN, remainder = 0.
- FSM states IDLE, MUL, DIV, DONE:
  - IDLE→DONE on accept of a base op, a special-case divide, or an illegal op.
  - IDLE→MUL or IDLE→DIV on accept of an M op.
  - MUL/DIV→DONE when the iteration counter reaches XLEN−1.
  - DONE→IDLE when out_ready=1.
- in_ready = (state==IDLE). Accept happens when in_valid & in_ready.
- out_valid = (state==DONE). result, less, zero and illegal are registered and stay stable while out_valid=1 & out_ready=0.
- flush: any state→IDLE on the next edge. out_valid drops and the held result is discarded. flush has priority over a simultaneous accept, which is ignored.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, less=0, zero=0, illegal=0, counter=0.
- Reset mid-iteration: outputs return to reset values immediately (asynchronous); no partial result is ever presented.
- Base op, illegal op or special-case divide: accepted at edge N, out_valid=1 after edge N+1.
- mul*/div*/rem*: accepted at edge N, out_valid=1 after edge N+XLEN+1 (33 cycles for XLEN=32).
- Throughput: one op in flight. The next accept can happen at the earliest in the cycle after the DONE→IDLE handshake edge.

## Configuration
- ALU_MULDIV_EN defined: M-group datapath, MUL/DIV states and the counter are built, with behaviour as above.
- ALU_MULDIV_EN undefined: no multiplier/divider logic. Every op[4]=1 bundle takes the 1-cycle path with result=0, zero=1, less=0, illegal=1. The MUL and DIV states are unreachable.

## Test plan
- add 0xFFFFFFFF + 1 (XLEN=32) → result 0x00000000, zero=1, out_valid exactly 1 cycle after accept.
- slt 0x80000000 vs 0x00000001 → result 1, less=1; sltu on the same operands → result 0, less=0.
- mulh −3 × 7 → result 0xFFFFFFFF; mul −3 × 7 → 0xFFFFFFEB; out_valid 33 cycles after accept.
- div 7/0 → 0xFFFFFFFF; rem 7/0 → 7; div 0x80000000/−1 → 0x80000000; each with 1-cycle latency.
- divu 100/7 with out_ready held low 5 cycles → result 14 held stable, in_ready=0 until handshake; remu → 2.
- Abort and reset mid-iteration:
  - flush asserted mid-divide at cycle 10 → IDLE next edge, no out_valid, and the next add 2+3 returns 5.
  - rst asserted mid-multiply → all outputs at reset values immediately.
